// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with per-frame target latching and slew limiting
module servo_pwm_multi #(
  parameter int CH     = 2,
  parameter int PERIOD = 2_000_000,
  parameter int MIN_PW = 100_000,
  parameter int MID_PW = 150_000,
  parameter int MAX_PW = 200_000,
  parameter int STEP   = 10_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2*CH-1:0] servo_instruction,
  output logic [CH-1:0]   servo,
  output logic            frame_tick
);

  localparam int CW = $clog2(PERIOD);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   wide_t;

  localparam cnt_t  LAST   = cnt_t'(PERIOD - 1);
  localparam cnt_t  PW_MIN = cnt_t'(MIN_PW);
  localparam cnt_t  PW_MID = cnt_t'(MID_PW);
  localparam cnt_t  PW_MAX = cnt_t'(MAX_PW);
  // A step wider than any pulse acts like an instant jump, so clamp it into range.
  localparam wide_t STEP_W = (STEP >= (1 << CW)) ? wide_t'(1 << CW) : wide_t'(STEP);

  if (!(MIN_PW <= MID_PW && MID_PW <= MAX_PW && MAX_PW < PERIOD)) begin : g_bad_pw
    $error("servo_pwm_multi: need MIN_PW <= MID_PW <= MAX_PW < PERIOD");
  end
  if (CH < 1 || CH > 8) begin : g_bad_ch
    $error("servo_pwm_multi: CH must be 1..8");
  end

  cnt_t           cnt_q, cnt_d;
  cnt_t           tgt_q [CH];
  cnt_t           tgt_d [CH];
  cnt_t           pw_q  [CH];
  cnt_t           pw_d  [CH];
  logic [CH-1:0]  servo_q, servo_d;
  logic           tick_q, tick_d;
  logic           frame_end;

  assign servo      = servo_q;
  assign frame_tick = tick_q;
  assign frame_end  = en && (cnt_q == LAST);

  function automatic cnt_t ramp(input cnt_t pw, input cnt_t tgt);
    wide_t pw_w, tgt_w, up, dn;
    cnt_t  res;
    pw_w  = {1'b0, pw};
    tgt_w = {1'b0, tgt};
    up    = pw_w + STEP_W;
    dn    = pw_w - STEP_W;
    res   = pw;
    if (STEP == 0) begin
      res = tgt;
    end else if (pw_w < tgt_w) begin
      res = (up > tgt_w) ? tgt : up[CW-1:0];
    end else if (pw_w > tgt_w) begin
      res = (pw_w >= tgt_w + STEP_W) ? dn[CW-1:0] : tgt;
    end
    return res;
  endfunction

  always_comb begin
    cnt_d  = (!en || frame_end) ? '0 : cnt_q + cnt_t'(1);
    tick_d = en && (cnt_q == '0);
    servo_d = '0;
    for (int c = 0; c < CH; c++) begin
      tgt_d[c]   = tgt_q[c];
      pw_d[c]    = pw_q[c];
      servo_d[c] = en && (cnt_q < pw_q[c]);
      // Instructions are only sampled on the last cycle so a running pulse never changes.
      if (frame_end) begin
        case (servo_instruction[2*c +: 2])
          2'b00:   tgt_d[c] = PW_MID;
          2'b01:   tgt_d[c] = PW_MIN;
          2'b10:   tgt_d[c] = PW_MAX;
          default: tgt_d[c] = tgt_q[c];
        endcase
        pw_d[c] = ramp(pw_q[c], tgt_d[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      servo_q <= '0;
      for (int c = 0; c < CH; c++) begin
        tgt_q[c] <= PW_MID;
        pw_q[c]  <= PW_MID;
      end
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      servo_q <= servo_d;
      tgt_q   <= tgt_d;
      pw_q    <= pw_d;
    end
  end

endmodule
